// File: rtl/rtype_ctrl.sv
// rtype_ctrl: four-state sequencer for R-type instructions.
// Accepts one instruction word in IDLE, decodes it into the ALU operation
// select, captures the ALU result and issues the write-back and PC-advance
// pulses. All outputs are registered.
module rtype_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] alu_c,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [3:0]  aluop,
    output logic [31:0] wb_data,
    output logic        reg_we,
    output logic        pc_en,
    output logic        illegal,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADDU = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    state_t      state;
    logic [31:0] instr_q;   // word captured on the accept edge
    logic        legal_q;   // decode verdict, used when entering WB
    logic [3:0]  dec_aluop;
    logic        dec_legal;

    // Decode the latched word: opcode must be zero and funct one of seven.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        dec_aluop = OP_BAD;
        dec_legal = 1'b0;
        if (instr_q[31:26] == 6'b000000) begin
            dec_legal = 1'b1;
            unique case (instr_q[5:0])
                6'h21:   dec_aluop = OP_ADDU;
                6'h23:   dec_aluop = OP_SUB;
                6'h22:   dec_aluop = OP_SUB;
                6'h20:   dec_aluop = OP_ADD;
                6'h24:   dec_aluop = OP_AND;
                6'h25:   dec_aluop = OP_OR;
                6'h2A:   dec_aluop = OP_SLT;
                default: begin
                    dec_aluop = OP_BAD;
                    dec_legal = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and every registered output; reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            instr_q     <= '0;
            legal_q     <= 1'b0;
            instr_ready <= 1'b1;
            rs_addr     <= '0;
            rt_addr     <= '0;
            rd_addr     <= '0;
            aluop       <= OP_ADDU;
            wb_data     <= '0;
            reg_we      <= 1'b0;
            pc_en       <= 1'b0;
            illegal     <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    rs_addr <= instr_q[25:21];
                    rt_addr <= instr_q[20:16];
                    rd_addr <= instr_q[15:11];
                    aluop   <= dec_aluop;
                    legal_q <= dec_legal;
                    state   <= EXEC;
                end
                EXEC: begin
                    // The ALU result is settled by now; the WB pulses are
                    // set up here so they are high exactly for the WB cycle.
                    wb_data    <= alu_c;
                    pc_en      <= 1'b1;
                    reg_we     <= legal_q && (rd_addr != 5'd0);
                    illegal    <= !legal_q;
                    retire_cnt <= retire_cnt + 32'd1;
                    state      <= WB;
                end
                WB: begin
                    pc_en       <= 1'b0;
                    reg_we      <= 1'b0;
                    illegal     <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_ctrl.sv
// tb_rtype_ctrl: directed bench with a scoreboard of expected retirements.
// Each issued instruction pushes its expected WB-cycle outputs; a monitor
// pops and compares whenever pc_en is seen.
module tb_rtype_ctrl;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic        we;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_c;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [3:0]  aluop;
    logic [31:0] wb_data;
    logic        reg_we, pc_en, illegal;
    logic [31:0] retire_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   exp_cnt  = 0;
    logic prev_pc  = 1'b0;

    rtype_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_c      (alu_c),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .aluop      (aluop),
        .wb_data    (wb_data),
        .reg_we     (reg_we),
        .pc_en      (pc_en),
        .illegal    (illegal),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rword(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {opc, rs, rt, rd, sh, fn};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] w, input logic [31:0] c,
                                    input logic [3:0] op, input bit legal);
        exp_t e;
        exp_cnt++;
        e.aluop = op;
        e.rs    = w[25:21];
        e.rt    = w[20:16];
        e.rd    = w[15:11];
        e.wb    = c;
        e.we    = legal && (w[15:11] != 5'd0);
        e.ill   = !legal;
        e.cnt   = exp_cnt;
        return e;
    endfunction

    // Monitor: compare the WB cycle against the scoreboard; pulses only in WB.
    always @(negedge clk) begin
        exp_t e;
        chk("pulse_outside_wb", {30'd0, reg_we & ~pc_en, illegal & ~pc_en}, 32'd0);
        if (pc_en) begin
            chk("pc_en_back_to_back", {31'd0, prev_pc}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_aluop",   {28'd0, aluop},   {28'd0, e.aluop});
                chk("wb_rs",      {27'd0, rs_addr}, {27'd0, e.rs});
                chk("wb_rt",      {27'd0, rt_addr}, {27'd0, e.rt});
                chk("wb_rd",      {27'd0, rd_addr}, {27'd0, e.rd});
                chk("wb_data",    wb_data,          e.wb);
                chk("wb_reg_we",  {31'd0, reg_we},  {31'd0, e.we});
                chk("wb_illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("wb_retire",  retire_cnt,       e.cnt);
            end
        end
        prev_pc = pc_en;
    end

    // One instruction through the full handshake, with latency checks.
    task automatic issue(input logic [31:0] w, input logic [31:0] c,
                         input logic [3:0] op, input bit legal);
        int k;
        sb.push_back(mk_exp(w, c, op, legal));
        @(negedge clk);
        instr       = w;
        alu_c       = c;
        instr_valid = 1'b1;
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        k = 1;
        while (!pc_en && k < 10) begin
            chk("ready_busy", {31'd0, instr_ready}, 32'd0);
            if (k == 2) chk("aluop_exec", {28'd0, aluop}, {28'd0, op});
            @(negedge clk);
            k++;
        end
        chk("wb_latency", k, 32'd3);
        chk("ready_wb", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("ready_back", {31'd0, instr_ready}, 32'd1);
        chk("pc_en_clear", {31'd0, pc_en}, 32'd0);
        chk("aluop_hold", {28'd0, aluop}, {28'd0, op});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  fn_tab [7];
        logic [3:0]  op_tab [7];
        logic [11:0] pc_mask;
        int          acc;

        fn_tab = '{6'h21, 6'h23, 6'h22, 6'h20, 6'h24, 6'h25, 6'h2A};
        op_tab = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};

        rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
        chk("rst_aluop",   {28'd0, aluop}, 32'd0);
        chk("rst_addrs",   {17'd0, rs_addr, rt_addr, rd_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_pulses",  {29'd0, reg_we, pc_en, illegal}, 32'd0);
        chk("rst_retire",  retire_cnt, 32'd0);

        // add $8,$9,$10
        issue(32'h012A4020, 32'h0000_0007, 4'b0010, 1'b1);

        // Legal funct sweep; one entry with a non-zero shamt.
        for (int i = 0; i < 7; i++) begin
            issue(rword(6'd0, 5'(i + 1), 5'(i + 11), 5'(i + 20), (i == 3) ? 5'h1F : 5'd0, fn_tab[i]),
                  32'hA000_0000 + 32'(i), op_tab[i], 1'b1);
        end

        // Illegal funct, illegal opcode, legal funct under a non-zero opcode.
        issue(32'h0000000C, 32'h1111_1111, 4'b1111, 1'b0);
        issue(32'h8C000000, 32'h2222_2222, 4'b1111, 1'b0);
        issue(32'h04001820, 32'h3333_3333, 4'b1111, 1'b0);

        // Write to $0 suppressed but retired.
        issue(32'h01090020, 32'h4444_4444, 4'b0010, 1'b1);

        // instr_valid held for 12 cycles: three accepts, pc_en at 3, 7, 11.
        for (int i = 0; i < 3; i++) sb.push_back(mk_exp(32'h00A51825, 32'h5555_5555, 4'b0100, 1'b1));
        @(negedge clk);
        instr       = 32'h00A51825;
        alu_c       = 32'h5555_5555;
        instr_valid = 1'b1;
        acc         = 0;
        for (int k = 0; k < 12; k++) begin
            pc_mask[k] = pc_en;
            if (instr_ready && instr_valid) acc++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", acc, 32'd3);
        chk("b2b_pc_mask", {20'd0, pc_mask}, {20'd0, 12'b1000_1000_1000});
        chk("b2b_idle_after", {30'd0, instr_ready, pc_en}, 32'd2);

        // Reset asserted during EXEC drops the in-flight instruction.
        @(negedge clk);
        instr       = 32'h012A4020;
        alu_c       = 32'h6666_6666;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        chk("rst_exec_ready",  {31'd0, instr_ready}, 32'd1);
        chk("rst_exec_pulses", {29'd0, reg_we, pc_en, illegal}, 32'd0);
        chk("rst_exec_retire", retire_cnt, 32'd0);
        chk("rst_exec_aluop",  {28'd0, aluop}, 32'd0);
        chk("rst_exec_wb",     wb_data, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_exec_no_pulse", {29'd0, reg_we, pc_en, illegal}, 32'd0);
        end

        // Counting restarts from zero after reset.
        issue(32'h012A402A, 32'h0000_0001, 4'b0101, 1'b1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
